// File: rtl/ahb_lite_master.sv
// ahb_lite_master: AHB-Lite initiator that turns one command into an incrementing transfer sequence.
// Define AHB_LITE_MASTER_ERR_ADDR_EN to add err_addr, the address of the beat that took an ERROR response.
module ahb_lite_master #(
    parameter int AW = 32,
    parameter int LW = 8
) (
    input  logic          HCLK,
    input  logic          HRESETn,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic          cmd_write,
    input  logic [AW-1:0] cmd_addr,
    input  logic [LW-1:0] cmd_len,
    input  logic [2:0]    cmd_size,
    input  logic          wdata_valid,
    output logic          wdata_ready,
    input  logic [31:0]   wdata,
    output logic          rdata_valid,
    output logic [31:0]   rdata,
    output logic          done,
    output logic          err,
`ifdef AHB_LITE_MASTER_ERR_ADDR_EN
    output logic [AW-1:0] err_addr,
`endif
    output logic [AW-1:0] HADDR,
    output logic [1:0]    HTRANS,
    output logic [2:0]    HSIZE,
    output logic [2:0]    HBURST,
    output logic          HWRITE,
    output logic [3:0]    HPROT,
    output logic [31:0]   HWDATA,
    input  logic          HREADY,
    input  logic          HRESP,
    input  logic [31:0]   HRDATA
);
    typedef enum logic [1:0] {IDLE, ADDR, LAST} state_t;
    localparam logic [1:0] TR_IDLE = 2'b00, TR_BUSY = 2'b01, TR_NONSEQ = 2'b10, TR_SEQ = 2'b11;

    state_t        state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [LW-1:0] len_q, len_d;
    logic [2:0]    size_q, size_d, burst_q, burst_d;
    logic [31:0]   hwdata_q, hwdata_d;
    logic          write_q, write_d, first_q, first_d, dphase_q, dphase_d;
    logic          done_q, done_d, err_q, err_d;
    logic          issue, err_now;
`ifdef AHB_LITE_MASTER_ERR_ADDR_EN
    logic [AW-1:0] daddr_q, daddr_d, err_addr_q, err_addr_d;
`endif

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        len_d    = len_q;
        size_d   = size_q;
        burst_d  = burst_q;
        hwdata_d = hwdata_q;
        write_d  = write_q;
        first_d  = first_q;
        dphase_d = dphase_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
`ifdef AHB_LITE_MASTER_ERR_ADDR_EN
        daddr_d    = daddr_q;
        err_addr_d = err_addr_q;
`endif
        err_now   = dphase_q & HRESP;
        cmd_ready = (state_q == IDLE);
        // An ERROR in the data phase cancels whatever address phase would otherwise be presented
        HTRANS = TR_IDLE;
        if (state_q == ADDR && !err_now)
            HTRANS = (write_q && !wdata_valid) ? (first_q ? TR_IDLE : TR_BUSY)
                   : (first_q || addr_q[9:0] == 10'd0) ? TR_NONSEQ : TR_SEQ;
        issue       = HTRANS[1] & HREADY;
        wdata_ready = issue & write_q;
        rdata_valid = dphase_q & HREADY & ~HRESP & ~write_q;
        if (HREADY)
            dphase_d = issue;
        if (cmd_valid && cmd_ready) begin
            state_d = ADDR;
            addr_d  = cmd_addr;
            len_d   = cmd_len;
            size_d  = (cmd_size > 3'd2) ? 3'd2 : cmd_size;
            burst_d = (cmd_len == '0) ? 3'b000 : 3'b001;
            write_d = cmd_write;
            first_d = 1'b1;
`ifdef AHB_LITE_MASTER_ERR_ADDR_EN
            err_addr_d = '0;
`endif
        end
        if (issue) begin
            addr_d  = addr_q + (AW'(1) << size_q);
            first_d = 1'b0;
            if (write_q)
                hwdata_d = wdata;
            if (len_q == '0)
                state_d = LAST;
            else
                len_d = len_q - LW'(1);
`ifdef AHB_LITE_MASTER_ERR_ADDR_EN
            daddr_d = addr_q;
`endif
        end
        if (state_q == LAST && dphase_q && HREADY) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = HRESP;
        end
        if (err_now && HREADY) begin
            state_d = IDLE;
            done_d  = 1'b1;
            err_d   = 1'b1;
        end
`ifdef AHB_LITE_MASTER_ERR_ADDR_EN
        if (err_now)
            err_addr_d = daddr_q;
`endif
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q  <= IDLE;
            addr_q   <= '0;
            len_q    <= '0;
            size_q   <= '0;
            burst_q  <= '0;
            hwdata_q <= '0;
            write_q  <= 1'b0;
            first_q  <= 1'b0;
            dphase_q <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef AHB_LITE_MASTER_ERR_ADDR_EN
            daddr_q    <= '0;
            err_addr_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            len_q    <= len_d;
            size_q   <= size_d;
            burst_q  <= burst_d;
            hwdata_q <= hwdata_d;
            write_q  <= write_d;
            first_q  <= first_d;
            dphase_q <= dphase_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef AHB_LITE_MASTER_ERR_ADDR_EN
            daddr_q    <= daddr_d;
            err_addr_q <= err_addr_d;
`endif
        end
    end

    assign HADDR  = addr_q;
    assign HSIZE  = size_q;
    assign HBURST = burst_q;
    assign HWRITE = write_q;
    assign HPROT  = 4'b0011;
    assign HWDATA = hwdata_q;
    assign rdata  = HRDATA;
    assign done   = done_q;
    assign err    = err_q;
`ifdef AHB_LITE_MASTER_ERR_ADDR_EN
    assign err_addr = err_addr_q;
`endif
endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Simple AHB-Lite initiator. Turns a single command (address, beat count, size, direction) into an incrementing AHB transfer sequence.
- Write data arrives on a valid/ready stream. Read data leaves as a valid pulse stream.
- Drives the slave side of the AHB-to-SSRAM path (and any other AHB-Lite slave) from DMA/test engines. It is the initiator counterpart of the team's AHB slave bridges.

Parameters:
- AW, 32, address width of HADDR and cmd_addr.
- LW, 8, width of cmd_len; a command carries cmd_len+1 beats (1..2^LW).

Ports:
- HCLK  input  1  clock
- HRESETn  input  1  asynchronous active-low reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high only in IDLE; command accepted when cmd_valid & cmd_ready
- cmd_write  input  1  1=write, 0=read
- cmd_addr  input  AW  start byte address; must be aligned to cmd_size
- cmd_len  input  LW  number of beats minus one
- cmd_size  input  3  HSIZE for every beat; values >2 are treated as 2
- wdata_valid  input  1  write data available
- wdata_ready  output  1  write data consumed this cycle
- wdata  input  32  write data
- rdata_valid  output  1  one-cycle read beat strobe; no backpressure
- rdata  output  32  read beat data
- done  output  1  one-cycle pulse when the command completes or aborts
- err  output  1  valid with done; 1 = aborted on ERROR response
- HADDR  output  AW  address
- HTRANS  output  2  transfer type
- HSIZE  output  3  transfer size
- HBURST  output  3  SINGLE (000) when cmd_len==0, else INCR (001)
- HWRITE  output  1  direction, constant for the whole command
- HPROT  output  4  fixed 4'b0011
- HWDATA  output  32  write data, registered, driven in the data phase
- HREADY  input  1  bus ready
- HRESP  input  1  0=OKAY, 1=ERROR
- HRDATA  input  32  read data

Behaviour:
- Reset values:
  - HTRANS=IDLE; HADDR, HWDATA, HSIZE and HWRITE = 0; HBURST=SINGLE.
  - cmd_ready=1; wdata_ready, rdata_valid, done and err = 0.
  - Beat counters = 0; state=IDLE.
- Reset mid-command drops the command immediately; no done pulse follows.
- State IDLE:
  - cmd_ready=1.
  - On accept: latch addr, len, size, write; go to ADDR.
  - The first address phase can appear the cycle after accept.
- State ADDR:
  - A beat is "issued" in a cycle with HTRANS in {NONSEQ, SEQ} and HREADY=1.
  - HTRANS = NONSEQ for the first beat, and for any beat whose address has bits [9:0]==0. This restarts the burst at a 1KB boundary.
  - Otherwise HTRANS = SEQ.
  - Write, wdata_valid=0: HTRANS=IDLE before the first beat, BUSY mid-burst. HADDR is held.
  - Write, wdata_valid=1 and the beat issues: wdata_ready=1 in that cycle; wdata is registered into HWDATA for the following data phase.
  - HADDR advances by 1<<size after each issued beat.
  - After the last beat issues, go to LAST.
- State LAST:
  - HTRANS=IDLE. Wait for the final data phase to see HREADY=1.
  - Next cycle: done=1, err=0; go to IDLE.
- Read data: rdata_valid=1 and rdata=HRDATA in any cycle where a read data phase completes with HREADY=1 and HRESP=0.
- Read latency: data returns one cycle after the beat issues, plus any slave wait states.
- Wait states: while HREADY=0, all address-phase outputs (HTRANS, HADDR, HSIZE, HWRITE, HBURST) and HWDATA are held.
- Error handling:
  - First ERROR cycle (HRESP=1, HREADY=0): HTRANS is forced to IDLE combinationally and the remaining beats are abandoned. Unissued write data is not consumed.
  - Second ERROR cycle (HRESP=1, HREADY=1): done=1 and err=1 on the next cycle; go to IDLE.
  - An errored read beat produces no rdata_valid.
- A new cmd_valid during an active command is not accepted; cmd_ready=0 until IDLE.
- HBURST and HSIZE are constant for the whole command. HBURST changes only on command accept.

Optional Feature:
- Macro AHB_LITE_MASTER_ERR_ADDR_EN adds output err_addr[AW-1:0].
  - It captures the HADDR of the beat that received the ERROR response.
  - It holds until the next command accept; reset value 0.
- Without the macro, the port and its register are absent, and error handling is otherwise identical.

Test Plan:
- Single write: cmd_addr=0x100, len=0, size=2, wdata=0xDEADBEEF valid.
  - Expect one NONSEQ with HBURST=SINGLE and HADDR=0x100.
  - Expect HWDATA=0xDEADBEEF in the next cycle, then done=1 and err=0.
- 4-beat read at 0x200, slave inserts 2 wait states on beat 2.
  - Expect NONSEQ 0x200, then SEQ 0x204/0x208/0x20C, with outputs held during the waits.
  - Expect 4 rdata_valid pulses matching HRDATA, then done.
- 3-beat byte write with wdata_valid low for 2 cycles after beat 1.
  - Expect HTRANS=BUSY for 2 cycles with HADDR=0x001 held, and wdata_ready only on issue.
  - Expect addresses 0x000, 0x001, 0x002.
- 1KB boundary: 4-beat word read at 0x3F8.
  - Expect NONSEQ 0x3F8, SEQ 0x3FC, NONSEQ 0x400, SEQ 0x404.
- ERROR on beat 2 of a 4-beat write.
  - Expect HTRANS=IDLE in the first ERROR cycle and no further wdata_ready.
  - Expect done=1 and err=1 one cycle after the second ERROR cycle.
  - With AHB_LITE_MASTER_ERR_ADDR_EN, err_addr = the address of beat 2.
- Reset asserted mid-burst: all outputs return to reset values asynchronously, no done pulse, and a new command is accepted after release.
